// File: rtl/mu0_bus_arbiter_if.sv
// rtl/mu0_bus_arbiter_if.sv - request/ack and memory-side bundle for mu0_bus_arbiter
//
// Purpose: groups the CPU port, loader port and memory control signals of the
// MU0 bus arbiter. The bidirectional databus is kept as a separate inout port
// on the arbiter itself.
//
// Modports:
//   slave  - the arbiter: takes c_*/l_* requests, returns acks, rdata, owner,
//            and drives mem_rq/rnw/addr towards mu0_memory.
//   master - the environment (CPU, loader, memory) seen from the other side.
//
// Signals:
//   c_rq/c_rnw/c_addr/c_wdata, c_ack  CPU request (level, held until ack) and ack pulse
//   l_rq/l_rnw/l_addr/l_wdata, l_ack  loader equivalents
//   rdata                             read data, valid while c_ack or l_ack is high
//   mem_rq, rnw, addr                 memory request, read/not-write, address
//   owner                             current/last granted port, 0 = CPU, 1 = loader

interface mu0_bus_arbiter_if #(
    parameter int ADDR = 12,
    parameter int DATA = 16
);
    logic            c_rq;
    logic            c_rnw;
    logic [ADDR-1:0] c_addr;
    logic [DATA-1:0] c_wdata;
    logic            c_ack;
    logic            l_rq;
    logic            l_rnw;
    logic [ADDR-1:0] l_addr;
    logic [DATA-1:0] l_wdata;
    logic            l_ack;
    logic [DATA-1:0] rdata;
    logic            mem_rq;
    logic            rnw;
    logic [ADDR-1:0] addr;
    logic            owner;

    modport slave (
        input  c_rq, c_rnw, c_addr, c_wdata,
        input  l_rq, l_rnw, l_addr, l_wdata,
        output c_ack, l_ack, rdata,
        output mem_rq, rnw, addr, owner
    );

    modport master (
        output c_rq, c_rnw, c_addr, c_wdata,
        output l_rq, l_rnw, l_addr, l_wdata,
        input  c_ack, l_ack, rdata,
        input  mem_rq, rnw, addr, owner
    );
endinterface

// File: rtl/mu0_bus_arbiter.sv
// rtl/mu0_bus_arbiter.sv - two-port (CPU/loader) arbiter for the mu0_memory port
//
// Purpose: serialises CPU and loader accesses onto the single memory port with
// a 3-state FSM (IDLE -> ACC -> DONE). A request sampled in IDLE is latched,
// presented to memory for one cycle (ACC), then acknowledged for one cycle
// (DONE) on the port that owns it.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   bus      mu0_bus_arbiter_if.slave: c_*/l_* requests and acks, rdata,
//            owner, mem_rq/rnw/addr to memory
//   databus  memory data bus; driven only during a write ACC cycle
//
// Configuration:
//   MU0_ARB_RR_EN  defined: round-robin on ties (the port that is not owner wins)
//                  undefined: fixed priority, loader wins every tie

module mu0_bus_arbiter #(
    parameter int ADDR = 12,
    parameter int DATA = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    mu0_bus_arbiter_if.slave        bus,
    inout  wire  [DATA-1:0]         databus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state_q,  state_d;
    logic            owner_q,  owner_d;
    logic            rnw_q,    rnw_d;
    logic [ADDR-1:0] addr_q,   addr_d;
    logic [DATA-1:0] wdata_q,  wdata_d;
    logic [DATA-1:0] rdata_q,  rdata_d;
    logic            c_ack_q,  c_ack_d;
    logic            l_ack_q,  l_ack_d;
    logic            mem_rq_q, mem_rq_d;
    logic            win_ld;

    // Winner selection, only consulted in IDLE.
    always_comb begin
`ifdef MU0_ARB_RR_EN
        if (bus.c_rq && bus.l_rq) begin
            win_ld = ~owner_q;
        end else begin
            win_ld = bus.l_rq;
        end
`else
        win_ld = bus.l_rq;
`endif
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        c_ack_d  = 1'b0;
        l_ack_d  = 1'b0;
        mem_rq_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.c_rq || bus.l_rq) begin
                    // Latch the winner so later changes on its inputs cannot
                    // disturb the access in flight.
                    owner_d  = win_ld;
                    rnw_d    = win_ld ? bus.l_rnw   : bus.c_rnw;
                    addr_d   = win_ld ? bus.l_addr  : bus.c_addr;
                    wdata_d  = win_ld ? bus.l_wdata : bus.c_wdata;
                    mem_rq_d = 1'b1;
                    state_d  = ACC;
                end
            end
            ACC: begin
                // Read data is taken from the bus at the edge that closes ACC.
                if (rnw_q) begin
                    rdata_d = databus;
                end
                c_ack_d = ~owner_q;
                l_ack_d = owner_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rnw_q    <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            c_ack_q  <= 1'b0;
            l_ack_q  <= 1'b0;
            mem_rq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            c_ack_q  <= c_ack_d;
            l_ack_q  <= l_ack_d;
            mem_rq_q <= mem_rq_d;
        end
    end

    assign bus.c_ack  = c_ack_q;
    assign bus.l_ack  = l_ack_q;
    assign bus.rdata  = rdata_q;
    assign bus.mem_rq = mem_rq_q;
    assign bus.rnw    = rnw_q;
    assign bus.addr   = addr_q;
    assign bus.owner  = owner_q;

    assign databus = (state_q == ACC && !rnw_q) ? wdata_q : {DATA{1'bz}};
endmodule

// File: tb/tb_mu0_bus_arbiter.sv
// tb/tb_mu0_bus_arbiter.sv - self-checking bench for mu0_bus_arbiter

module tb_mu0_bus_arbiter;
    logic clk;
    logic rst;
    wire  [15:0] databus;

    mu0_bus_arbiter_if #(.ADDR(12), .DATA(16)) bus();

    mu0_bus_arbiter #(.ADDR(12), .DATA(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .databus (databus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model on the far side of the arbiter.
    logic [15:0] mem [0:4095];
    assign databus = (bus.mem_rq && bus.rnw) ? mem[bus.addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (bus.mem_rq && !bus.rnw) mem[bus.addr] <= databus;
    end

    typedef struct {
        bit          port;   // 0 = CPU, 1 = loader
        bit          rnw;
        logic [11:0] addr;
        logic [15:0] data;   // write data, or expected read data
    } exp_t;

    typedef struct {
        bit          port;
        bit          rnw;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_mem [0:4095];
    int          n_cmp;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit port, input bit rnw, input logic [11:0] a, input logic [15:0] d);
        exp_t e;
        e.port = port;
        e.rnw  = rnw;
        e.addr = a;
        e.data = rnw ? exp_mem[a] : d;
        if (!rnw) exp_mem[a] = d;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input bit port, input bit rq, input bit rnw, input logic [11:0] a, input logic [15:0] d);
        if (port) begin
            bus.l_rq = rq; bus.l_rnw = rnw; bus.l_addr = a; bus.l_wdata = d;
        end else begin
            bus.c_rq = rq; bus.c_rnw = rnw; bus.c_addr = a; bus.c_wdata = d;
        end
    endtask

    task automatic drop_req(input bit port);
        if (port) bus.l_rq = 1'b0;
        else      bus.c_rq = 1'b0;
    endtask

    // Counts negedges until the given port acks; 0 on timeout.
    task automatic wait_ack(input bit port, output int n);
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ((port ? bus.l_ack : bus.c_ack) === 1'b1) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: checks the memory phase against the queue head and
    // pops the head on each ack.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rq) begin
                if (exp_q.size() == 0) begin
                    chk("mem_rq_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[0];
                    chk("acc_rnw",  {31'd0, bus.rnw}, {31'd0, mon_e.rnw});
                    chk("acc_addr", {20'd0, bus.addr}, {20'd0, mon_e.addr});
                    if (!mon_e.rnw) chk("acc_databus", {16'd0, databus}, {16'd0, mon_e.data});
                end
            end
            if (bus.c_ack || bus.l_ack) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", {30'd0, bus.l_ack, bus.c_ack}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_port", {30'd0, bus.l_ack, bus.c_ack}, mon_e.port ? 32'd2 : 32'd1);
                    chk("owner", {31'd0, bus.owner}, {31'd0, mon_e.port});
                    if (mon_e.rnw) chk("rdata", {16'd0, bus.rdata}, {16'd0, mon_e.data});
                end
            end
        end
    end

    task automatic access(input bit port, input bit rnw, input logic [11:0] a, input logic [15:0] d);
        int n;
        @(posedge clk); #1;
        push_exp(port, rnw, a, d);
        set_req(port, 1'b1, rnw, a, d);
        wait_ack(port, n);
        chk("ack_latency", n, 32'd3);
        drop_req(port);
    endtask

    vec_t        vecs [7];
    logic [15:0] prog [6];
    int          n;
    bit          first_ld;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 16'h0000;
            exp_mem[i] = 16'h0000;
        end
        vecs[0] = '{1'b1, 1'b0, 12'h010, 16'h0001, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 12'h010, 16'h0000, 16'h0001};
        vecs[2] = '{1'b0, 1'b0, 12'h020, 16'h00FF, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 12'h020, 16'h0000, 16'h00FF};
        vecs[4] = '{1'b0, 1'b0, 12'hFFF, 16'hFFFF, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 12'hFFF, 16'h0000, 16'hFFFF};
        vecs[6] = '{1'b0, 1'b1, 12'h010, 16'h0000, 16'h0001};
        prog[0] = 16'h8010; prog[1] = 16'h9011; prog[2] = 16'hB003;
        prog[3] = 16'hA003; prog[4] = 16'hC012; prog[5] = 16'h7000;

        set_req(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
        set_req(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_rq", {31'd0, bus.mem_rq}, 32'd0);
        chk("rst_rnw",    {31'd0, bus.rnw},    32'd1);
        chk("rst_addr",   {20'd0, bus.addr},   32'd0);
        chk("rst_c_ack",  {31'd0, bus.c_ack},  32'd0);
        chk("rst_l_ack",  {31'd0, bus.l_ack},  32'd0);
        chk("rst_rdata",  {16'd0, bus.rdata},  32'd0);
        chk("rst_owner",  {31'd0, bus.owner},  32'd0);
        rst = 1'b0;

        // Table-driven single accesses; reads carry their own expected data.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (vecs[i].rnw) begin
                mon_e.port = vecs[i].port; mon_e.rnw = 1'b1;
                mon_e.addr = vecs[i].addr; mon_e.data = vecs[i].exp_rdata;
                exp_q.push_back(mon_e);
            end else begin
                push_exp(vecs[i].port, 1'b0, vecs[i].addr, vecs[i].wdata);
            end
            set_req(vecs[i].port, 1'b1, vecs[i].rnw, vecs[i].addr, vecs[i].wdata);
            wait_ack(vecs[i].port, n);
            chk("vec_latency", n, 32'd3);
            drop_req(vecs[i].port);
        end

        // Make the loader the last owner, then a simultaneous tie.
        access(1'b1, 1'b0, 12'h011, 16'h0005);
        first_ld = 1'b1;
`ifdef MU0_ARB_RR_EN
        first_ld = 1'b0;
`endif
        @(posedge clk); #1;
        if (first_ld) begin
            push_exp(1'b1, 1'b0, 12'h011, 16'h000A);
            push_exp(1'b0, 1'b1, 12'h011, 16'h0000);
        end else begin
            push_exp(1'b0, 1'b1, 12'h011, 16'h0000);
            push_exp(1'b1, 1'b0, 12'h011, 16'h000A);
        end
        set_req(1'b0, 1'b1, 1'b1, 12'h011, 16'h0000);
        set_req(1'b1, 1'b1, 1'b0, 12'h011, 16'h000A);
        wait_ack(first_ld, n);
        chk("tie_first_latency", n, 32'd3);
        drop_req(first_ld);
        wait_ack(~first_ld, n);
        chk("tie_second_spacing", n, 32'd3);
        drop_req(~first_ld);

        // Back-to-back program load with l_rq held throughout.
        @(posedge clk); #1;
        push_exp(1'b1, 1'b0, 12'h000, prog[0]);
        set_req(1'b1, 1'b1, 1'b0, 12'h000, prog[0]);
        for (int i = 0; i < 6; i++) begin
            wait_ack(1'b1, n);
            chk("load_spacing", n, 32'd3);
            if (i < 5) begin
                push_exp(1'b1, 1'b0, 12'(i + 1), prog[i + 1]);
                set_req(1'b1, 1'b1, 1'b0, 12'(i + 1), prog[i + 1]);
            end else begin
                drop_req(1'b1);
            end
        end
        access(1'b0, 1'b1, 12'h003, 16'h0000);
        chk("prog_word3", {16'd0, exp_mem[3]}, 32'h0000_A003);

        // Reset during ACC of a CPU write; c_rq stays held across it.
        @(posedge clk); #1;
        push_exp(1'b0, 1'b0, 12'h030, 16'h1234);
        set_req(1'b0, 1'b1, 1'b0, 12'h030, 16'h1234);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.mem_rq) begin
                n = 1;
                break;
            end
        end
        chk("rst_test_reached_acc", n, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_acc_mem_rq", {31'd0, bus.mem_rq}, 32'd0);
        chk("rst_acc_c_ack",  {31'd0, bus.c_ack},  32'd0);
        chk("rst_acc_owner",  {31'd0, bus.owner},  32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        chk("rst_hold_c_ack", {31'd0, bus.c_ack}, 32'd0);
        chk("rst_hold_mem_rq", {31'd0, bus.mem_rq}, 32'd0);
        #2;
        rst = 1'b0;
        push_exp(1'b0, 1'b0, 12'h030, 16'h1234);
        wait_ack(1'b0, n);
        chk("rst_reservice_latency", n, 32'd2);
        drop_req(1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("mem_0x030", {16'd0, mem[12'h030]}, 32'h0000_1234);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
